// File: rtl/md_pkg.sv
// md_pkg: shared state encoding, op codes and counter sizing for the MULT/DIV sequencer.
package md_pkg;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} mdState_t;
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);
endpackage

// File: rtl/md_booth_step.sv
// md_booth_step: one radix-2 Booth iteration on {acc,q,qm1}, add/sub then arithmetic shift right.
module md_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   accNext,
  output logic [WIDTH-1:0] qNext,
  output logic             qm1Next
);
  logic [WIDTH:0] mExt, sum;
  // acc is one bit wider than M so that -(-2^(W-1)) stays representable
  assign mExt = {m[WIDTH-1], m};
  assign sum = (q[0] && !qm1) ? acc - mExt : (!q[0] && qm1) ? acc + mExt : acc;
  assign accNext = {sum[WIDTH], sum[WIDTH:1]};
  assign qNext = {sum[0], q[WIDTH-1:1]};
  assign qm1Next = q[0];
endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed Booth MULT / restoring DIV, one step per clock, result to HI/LO.
// Define MD_ABORT_EN to add the abort port that cancels a running op.
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
`ifdef MD_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdState_t state, nextState;
  logic [MD_CNT_W-1:0] cnt;
  logic [WIDTH:0] acc, boothAcc, divTrial;
  logic [WIDTH-1:0] q, m, boothQ, absA, absB, remNext, quoNext;
  logic qm1, boothQm1, negQ, negR, div0R, abortReq, lastStep, divFits, divByZero;

`ifdef MD_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  md_booth_step #(.WIDTH(WIDTH)) booth (
    .acc(acc), .q(q), .qm1(qm1), .m(m),
    .accNext(boothAcc), .qNext(boothQ), .qm1Next(boothQm1)
  );

  assign absA = src_a[WIDTH-1] ? -src_a : src_a;
  assign absB = src_b[WIDTH-1] ? -src_b : src_b;
  assign divByZero = (op == MD_OP_DIV) && (src_b == '0);
  // restoring divide: acc holds the partial remainder, q shifts dividend out / quotient in
  assign divTrial = {acc[WIDTH-1:0], q[WIDTH-1]} - {1'b0, m};
  assign divFits = !divTrial[WIDTH];
  assign remNext = divFits ? divTrial[WIDTH-1:0] : {acc[WIDTH-2:0], q[WIDTH-1]};
  assign quoNext = {q[WIDTH-2:0], divFits};
  assign lastStep = (cnt == MD_CNT_W'(1)) && !abortReq;

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign div0 = done && div0R;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = divByZero ? DONE : (op == MD_OP_DIV) ? DIV_RUN : MUL_RUN;
      MUL_RUN, DIV_RUN: nextState = abortReq ? IDLE : (cnt == MD_CNT_W'(1)) ? DONE : state;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      qm1 <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      div0R <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= MD_CNT_W'(WIDTH);
          acc <= '0;
          qm1 <= 1'b0;
          q <= (op == MD_OP_DIV) ? absA : src_b;
          m <= (op == MD_OP_DIV) ? absB : src_a;
          negQ <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
          negR <= src_a[WIDTH-1];
          div0R <= divByZero;
        end
        MUL_RUN: begin
          cnt <= cnt - MD_CNT_W'(1);
          acc <= boothAcc;
          q <= boothQ;
          qm1 <= boothQm1;
          if (lastStep) {hi, lo} <= {boothAcc[WIDTH-1:0], boothQ};
        end
        DIV_RUN: begin
          cnt <= cnt - MD_CNT_W'(1);
          acc <= {1'b0, remNext};
          q <= quoNext;
          if (lastStep) begin
            lo <= negQ ? -quoNext : quoNext;
            hi <= negR ? -remNext : remNext;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: table vectors, corner sequences and random ops checked against an arithmetic model.
module tb_mult_div_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic busy, done, div0;
  logic [31:0] hi, lo;
`ifdef MD_ABORT_EN
  logic abort = 1'b0;
`endif
  int errors = 0, checks = 0;
  logic [31:0] mHi = '0, mLo = '0;

  typedef struct {
    logic o;
    logic [31:0] a, b, eHi, eLo;
  } vec_t;
  vec_t vecs[7];

  always #5 clock = ~clock;

  mult_div_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
`ifdef MD_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic d0);
    longint p, qv, rv;
    h = mHi;
    l = mLo;
    d0 = 1'b0;
    if (!o) begin
      p = longint'($signed(a)) * longint'($signed(b));
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) d0 = 1'b1;
    else begin
      qv = longint'($signed(a)) / longint'($signed(b));
      rv = longint'($signed(a)) % longint'($signed(b));
      h = rv[31:0];
      l = qv[31:0];
    end
  endfunction

  task automatic doOp(input logic o, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clock);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic runCheck(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eHi, input logic [31:0] eLo, input logic eD0);
    int lat;
    doOp(o, a, b, lat);
    chk({name, "_latency"}, 64'(lat), eD0 ? 64'd1 : 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(eHi));
    chk({name, "_lo"}, 64'(lo), 64'(eLo));
    chk({name, "_div0"}, 64'(div0), 64'(eD0));
    @(negedge clock);
    chk({name, "_done_pulse"}, 64'({done, busy}), 64'd0);
    mHi = eHi;
    mLo = eLo;
  endtask

  initial begin
    int lat, nDone, first;
    logic [31:0] gh, gl, eh, el;
    logic ed, o;
    logic [31:0] a, b;
    repeat (3) @(negedge clock);
    chk("reset_outs", {busy, done, div0}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", 64'(busy), 64'd0);

    vecs[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1};
    vecs[6] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    for (int i = 0; i < 7; i++) runCheck($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
                                          vecs[i].eHi, vecs[i].eLo, 1'b0);

    runCheck("div_by_zero", 1'b1, 32'd5, 32'd0, mHi, mLo, 1'b1);

    // start pulsed mid-MULT must be ignored
    model(1'b0, 32'd12345, 32'hFFFFFD5A, eh, el, ed);
    @(negedge clock);
    start = 1'b1; op = 1'b0; src_a = 32'd12345; src_b = 32'hFFFFFD5A;
    @(negedge clock);
    start = 1'b0;
    nDone = 0; first = 0; gh = '0; gl = '0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd3; end
      if (n == 6) start = 1'b0;
      if (n == 20) chk("hilo_hold_midrun", {hi, lo}, {mHi, mLo});
      if (done) begin
        nDone++;
        if (first == 0) begin first = n; gh = hi; gl = lo; end
      end
      @(negedge clock);
    end
    chk("busy_start_done_count", 64'(nDone), 64'd1);
    chk("busy_start_latency", 64'(first), 64'd33);
    chk("busy_start_result", {gh, gl}, {eh, el});
    mHi = eh; mLo = el;

    // start while leaving DONE is dropped
    doOp(1'b0, 32'd3, 32'd4, lat);
    chk("leave_done_latency", 64'(lat), 64'd33);
    start = 1'b1; op = 1'b0; src_a = 32'd5; src_b = 32'd5;
    @(negedge clock);
    start = 1'b0;
    chk("leave_done_ignored", 64'(busy), 64'd0);
    chk("leave_done_result", {hi, lo}, {32'd0, 32'd12});
    mHi = 32'd0; mLo = 32'd12;

`ifdef MD_ABORT_EN
    @(negedge clock);
    start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    nDone = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) nDone++;
      @(negedge clock);
    end
    chk("abort_no_done", 64'(nDone), 64'd0);
    chk("abort_hilo", {hi, lo}, {mHi, mLo});
`endif

    // asynchronous reset mid-DIV
    @(negedge clock);
    start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_outs", {busy, done, div0}, 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    nDone = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) nDone++;
      @(negedge clock);
    end
    chk("midreset_no_done", 64'(nDone), 64'd0);
    mHi = '0; mLo = '0;

    for (int i = 0; i < 30; i++) begin
      int r;
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      r = int'($urandom_range(0, 9));
      if (r == 0) b = '0;
      else if (r < 5) b = 32'($urandom_range(1, 50));
      if (r == 1 || r == 2) b = -b;
      if (r == 3) a = 32'($urandom_range(0, 200));
      model(o, a, b, eh, el, ed);
      runCheck($sformatf("rnd%0d", i), o, a, b, eh, el, ed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
